// File: rtl/filter_pkg.sv
// ----------------------------------------------------------------------------
// filter_pkg
// Shared types and constants for the filter stream switch.
//   pix_stream_t       : one write-stream beat (we/addr/data) at the default
//                        QVGA / RGB565 widths
//   sw_state_e         : channel-switch controller states
//   FRAME_PIXELS_QVGA  : pixels in one 320x240 frame
//   PIX_ADDR_W/DATA_W  : default write-address and pixel widths
// ----------------------------------------------------------------------------
package filter_pkg;

    localparam int FRAME_PIXELS_QVGA = 320 * 240;
    localparam int PIX_ADDR_W        = 17;
    localparam int PIX_DATA_W        = 16;

    typedef struct packed {
        logic                  we;
        logic [PIX_ADDR_W-1:0] addr;
        logic [PIX_DATA_W-1:0] data;
    } pix_stream_t;

    // RUN: routing active_sel; PENDING: waiting for a frame boundary;
    // FLUSH: new channel routed but frame-buffer writes suppressed.
    typedef enum logic [1:0] {
        SW_RUN     = 2'b00,
        SW_PENDING = 2'b01,
        SW_FLUSH   = 2'b10
    } sw_state_e;

endpackage

// File: rtl/filter_stream_switch_eof_detect.sv
// ----------------------------------------------------------------------------
// stream_eof_detect
// Per-channel end-of-frame comparator. A channel is at end-of-frame when it
// writes the last pixel address of the frame in the current cycle.
//   we_bus   in  N_CH         per-channel write enable
//   addr_bus in  N_CH*ADDR_W  per-channel address, channel k at [k*ADDR_W +: ADDR_W]
//   eof      out N_CH         combinational end-of-frame flags
// ----------------------------------------------------------------------------
module stream_eof_detect
    import filter_pkg::*;
#(
    parameter int N_CH         = 16,
    parameter int ADDR_W       = PIX_ADDR_W,
    parameter int FRAME_PIXELS = FRAME_PIXELS_QVGA
) (
    input  logic [N_CH-1:0]        we_bus,
    input  logic [N_CH*ADDR_W-1:0] addr_bus,
    output logic [N_CH-1:0]        eof
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);

    // Compare every channel against the last frame address in parallel.
    always_comb begin
        eof = '0;
        for (int k = 0; k < N_CH; k++) begin
            eof[k] = we_bus[k] && (addr_bus[k*ADDR_W +: ADDR_W] == LAST_ADDR);
        end
    end

endmodule

// File: rtl/filter_stream_switch.sv
// ----------------------------------------------------------------------------
// filter_stream_switch
// Routes one of N_CH filter write streams to the frame-buffer write port.
// A requested channel change only takes effect at an end-of-frame of the
// channel currently routed (or after TIMEOUT cycles without one), so the
// frame buffer never holds a torn frame. After a switch, FLUSH_FRAMES frames
// of the new channel are kept out of the frame buffer. Channels flagged in
// POST_MASK take their frame-buffer stream from the shared post-stage return.
//
// Ports
//   clk                          in   system clock
//   reset                        in   synchronous, active-low reset
//   sel                          in   requested channel (level)
//   we_bus/addr_bus/data_bus     in   per-channel write streams
//   post_in_we/addr/data         out  active stream to post-stage, registered
//   post_out_we/addr/data        in   post-stage return stream
//   o_we/o_addr/o_data           out  frame-buffer write stream, registered
//   active_sel                   out  channel currently routed
//   busy                         out  switch in progress (PENDING or FLUSH)
//   frame_done                   out  pulse the cycle after an active EOF
// ----------------------------------------------------------------------------
module filter_stream_switch
    import filter_pkg::*;
#(
    parameter int              N_CH         = 16,
    parameter int              ADDR_W       = PIX_ADDR_W,
    parameter int              DATA_W       = PIX_DATA_W,
    parameter int              FRAME_PIXELS = FRAME_PIXELS_QVGA,
    parameter int              DEFAULT_SEL  = 0,
    parameter int              FLUSH_FRAMES = 1,
    parameter logic [N_CH-1:0] POST_MASK    = '0,
    parameter int              TIMEOUT      = 2**20,
    localparam int             SEL_W        = $clog2(N_CH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [SEL_W-1:0]       sel,
    input  logic [N_CH-1:0]        we_bus,
    input  logic [N_CH*ADDR_W-1:0] addr_bus,
    input  logic [N_CH*DATA_W-1:0] data_bus,
    output logic                   post_in_we,
    output logic [ADDR_W-1:0]      post_in_addr,
    output logic [DATA_W-1:0]      post_in_data,
    input  logic                   post_out_we,
    input  logic [ADDR_W-1:0]      post_out_addr,
    input  logic [DATA_W-1:0]      post_out_data,
    output logic                   o_we,
    output logic [ADDR_W-1:0]      o_addr,
    output logic [DATA_W-1:0]      o_data,
    output logic [SEL_W-1:0]       active_sel,
    output logic                   busy,
    output logic                   frame_done
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam int FC_W  = $clog2(FLUSH_FRAMES + 2);

    localparam logic [SEL_W-1:0] DEF_SEL  = SEL_W'(DEFAULT_SEL);
    localparam logic [SEL_W:0]   N_CH_L   = (SEL_W+1)'(N_CH);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(FLUSH_FRAMES);

    sw_state_e         state_r;
    logic [SEL_W-1:0]  active_sel_r;
    logic [SEL_W-1:0]  pend_sel_r;
    logic [TMO_W-1:0]  tmo_cnt_r;
    logic [FC_W-1:0]   flush_cnt_r;

    logic [ADDR_W-1:0] addr_arr_s [N_CH];
    logic [DATA_W-1:0] data_arr_s [N_CH];
    logic [N_CH-1:0]   eof_vec_s;

    logic              cur_we_s;
    logic [ADDR_W-1:0] cur_addr_s;
    logic [DATA_W-1:0] cur_data_s;
    logic              eof_act_s;
    logic              sel_ok_s;
    logic              flushing_s;
    logic              tmo_hit_s;
    logic              flush_last_s;

    // Unpacked per-channel views of the flat buses for variable indexing.
    for (genvar k = 0; k < N_CH; k++) begin : g_split
        assign addr_arr_s[k] = addr_bus[k*ADDR_W +: ADDR_W];
        assign data_arr_s[k] = data_bus[k*DATA_W +: DATA_W];
    end

    stream_eof_detect #(
        .N_CH         (N_CH),
        .ADDR_W       (ADDR_W),
        .FRAME_PIXELS (FRAME_PIXELS)
    ) u_eof (
        .we_bus   (we_bus),
        .addr_bus (addr_bus),
        .eof      (eof_vec_s)
    );

    // Select the active channel's stream and derive per-cycle control terms.
    always_comb begin
        cur_we_s     = we_bus[active_sel_r];
        cur_addr_s   = addr_arr_s[active_sel_r];
        cur_data_s   = data_arr_s[active_sel_r];
        eof_act_s    = eof_vec_s[active_sel_r];
        // Out-of-range requests are ignored entirely.
        sel_ok_s     = ({1'b0, sel} < N_CH_L);
        flushing_s   = (state_r == SW_FLUSH);
        tmo_hit_s    = (tmo_cnt_r == TMO_LAST);
        flush_last_s = ((flush_cnt_r + FC_W'(1)) == FC_LAST);
    end

    // Output registers: post-stage feed always follows the bypass stream;
    // the frame-buffer stream comes from the post-stage only for masked
    // channels, so stale post-stage beats vanish as soon as we switch away.
    always_ff @(posedge clk) begin
        if (!reset) begin
            post_in_we   <= 1'b0;
            post_in_addr <= '0;
            post_in_data <= '0;
            o_we         <= 1'b0;
            o_addr       <= '0;
            o_data       <= '0;
            frame_done   <= 1'b0;
        end else begin
            post_in_we   <= cur_we_s;
            post_in_addr <= cur_addr_s;
            post_in_data <= cur_data_s;
            frame_done   <= eof_act_s;
            if (POST_MASK[active_sel_r]) begin
                o_we   <= post_out_we & ~flushing_s;
                o_addr <= post_out_addr;
                o_data <= post_out_data;
            end else begin
                o_we   <= cur_we_s & ~flushing_s;
                o_addr <= cur_addr_s;
                o_data <= cur_data_s;
            end
        end
    end

    // Channel-switch controller with its timeout and flush counters.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r      <= SW_RUN;
            active_sel_r <= DEF_SEL;
            pend_sel_r   <= DEF_SEL;
            tmo_cnt_r    <= '0;
            flush_cnt_r  <= '0;
        end else begin
            case (state_r)
                SW_RUN: begin
                    if (sel_ok_s && (sel != active_sel_r)) begin
                        pend_sel_r <= sel;
                        tmo_cnt_r  <= '0;
                        state_r    <= SW_PENDING;
                    end
                end
                SW_PENDING: begin
                    if (sel_ok_s) begin
                        pend_sel_r <= sel;
                    end
                    if (sel == active_sel_r) begin
                        // Request withdrawn before any boundary: nothing changes.
                        state_r <= SW_RUN;
                    end else if (eof_act_s || tmo_hit_s) begin
                        // The EOF pixel itself still belongs to the old channel
                        // and is written this cycle by the output registers.
                        active_sel_r <= pend_sel_r;
                        flush_cnt_r  <= '0;
                        if (FLUSH_FRAMES == 0) begin
                            state_r <= SW_RUN;
                        end else begin
                            state_r <= SW_FLUSH;
                        end
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
                    end
                end
                SW_FLUSH: begin
                    if (eof_act_s) begin
                        if (flush_last_s) begin
                            if (sel_ok_s && (sel != active_sel_r)) begin
                                pend_sel_r <= sel;
                                tmo_cnt_r  <= '0;
                                state_r    <= SW_PENDING;
                            end else begin
                                state_r <= SW_RUN;
                            end
                        end else begin
                            flush_cnt_r <= flush_cnt_r + FC_W'(1);
                        end
                    end
                end
                default: begin
                    state_r <= SW_RUN;
                end
            endcase
        end
    end

    assign active_sel = active_sel_r;
    assign busy       = (state_r != SW_RUN);

endmodule

// File: tb/tb_filter_stream_switch.sv
module tb_filter_stream_switch;

    localparam int N_CH         = 6;
    localparam int ADDR_W       = 17;
    localparam int DATA_W       = 16;
    localparam int FP           = 48;
    localparam int FLUSH_FRAMES = 1;
    localparam int TIMEOUT      = 64;
    localparam int SEL_W        = 3;
    localparam logic [N_CH-1:0] POST_MASK = 6'b010000;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [SEL_W-1:0]       sel;
    logic [N_CH-1:0]        we_bus;
    logic [N_CH*ADDR_W-1:0] addr_bus;
    logic [N_CH*DATA_W-1:0] data_bus;
    logic                   post_in_we;
    logic [ADDR_W-1:0]      post_in_addr;
    logic [DATA_W-1:0]      post_in_data;
    logic                   post_out_we;
    logic [ADDR_W-1:0]      post_out_addr;
    logic [DATA_W-1:0]      post_out_data;
    logic                   o_we;
    logic [ADDR_W-1:0]      o_addr;
    logic [DATA_W-1:0]      o_data;
    logic [SEL_W-1:0]       active_sel;
    logic                   busy;
    logic                   frame_done;

    always #5 clk = ~clk;

    filter_stream_switch #(
        .N_CH(N_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FRAME_PIXELS(FP),
        .DEFAULT_SEL(0), .FLUSH_FRAMES(FLUSH_FRAMES), .POST_MASK(POST_MASK),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .sel(sel),
        .we_bus(we_bus), .addr_bus(addr_bus), .data_bus(data_bus),
        .post_in_we(post_in_we), .post_in_addr(post_in_addr), .post_in_data(post_in_data),
        .post_out_we(post_out_we), .post_out_addr(post_out_addr), .post_out_data(post_out_data),
        .o_we(o_we), .o_addr(o_addr), .o_data(o_data),
        .active_sel(active_sel), .busy(busy), .frame_done(frame_done)
    );

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- stimulus ----------------
    int              cnt [N_CH];
    logic [N_CH-1:0] stall;
    int              prob;
    logic [DATA_W-1:0] d0, d1, d2;
    logic [ADDR_W-1:0] a0, a1, a2;

    // Each channel ramps through its frame addresses at a random pace; the
    // post-stage stub returns what it was fed last edge with inverted data.
    task automatic drive_inputs();
        for (int k = 0; k < N_CH; k++) begin
            if (!stall[k] && ($urandom_range(0, 99) < prob)) begin
                we_bus[k] = 1'b1;
                addr_bus[k*ADDR_W +: ADDR_W] = ADDR_W'(cnt[k]);
                cnt[k] = (cnt[k] + 1) % FP;
            end else begin
                we_bus[k] = 1'b0;
                addr_bus[k*ADDR_W +: ADDR_W] = ADDR_W'(cnt[k]);
            end
            data_bus[k*DATA_W +: DATA_W] = DATA_W'($urandom);
        end
        d2 = d1; d1 = d0; d0 = data_bus[4*DATA_W +: DATA_W];
        a2 = a1; a1 = a0; a0 = addr_bus[4*ADDR_W +: ADDR_W];
        post_out_we   = post_in_we;
        post_out_addr = post_in_addr;
        post_out_data = post_in_data ^ 16'hFFFF;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drive_inputs();
        @(negedge clk);
    endtask

    task automatic wait_until_active(input int target, input int limit, output int n);
        n = 0;
        while (int'(active_sel) != target && n < limit) begin
            step();
            n++;
        end
        chk("wait_active", 32'(active_sel), 32'(target));
    endtask

    task automatic wait_until_idle(input int limit);
        int n;
        n = 0;
        while (busy && n < limit) begin
            step();
            n++;
        end
        chk("wait_idle", 32'(busy), 32'd0);
    endtask

    // ---------------- reference model ----------------
    // Tracks which channel the frame buffer should be listening to, from
    // the switching rules, and what each output must show one edge later.
    int m_state;   // 0 running, 1 waiting for boundary, 2 discarding frames
    int m_act, m_pend, m_tmo, m_fc;
    logic              e_o_we, e_pi_we, e_fd, e_busy;
    logic [ADDR_W-1:0] e_o_addr, e_pi_addr;
    logic [DATA_W-1:0] e_o_data, e_pi_data;
    logic [SEL_W-1:0]  e_act;

    always @(posedge clk) begin : model
        int s, old_pend;
        logic cw, eof;
        logic [ADDR_W-1:0] ca;
        logic [DATA_W-1:0] cd;
        if (!reset) begin
            m_state = 0; m_act = 0; m_pend = 0; m_tmo = 0; m_fc = 0;
            e_o_we = 1'b0; e_o_addr = '0; e_o_data = '0;
            e_pi_we = 1'b0; e_pi_addr = '0; e_pi_data = '0;
            e_fd = 1'b0;
        end else begin
            cw  = we_bus[m_act];
            ca  = addr_bus[m_act*ADDR_W +: ADDR_W];
            cd  = data_bus[m_act*DATA_W +: DATA_W];
            eof = cw && (int'(ca) == FP - 1);
            e_pi_we = cw; e_pi_addr = ca; e_pi_data = cd;
            e_fd = eof;
            if (POST_MASK[m_act]) begin
                e_o_we = post_out_we && (m_state != 2);
                e_o_addr = post_out_addr; e_o_data = post_out_data;
            end else begin
                e_o_we = cw && (m_state != 2);
                e_o_addr = ca; e_o_data = cd;
            end
            s = int'(sel);
            if (m_state == 0) begin
                if (s < N_CH && s != m_act) begin
                    m_pend = s; m_tmo = 0; m_state = 1;
                end
            end else if (m_state == 1) begin
                old_pend = m_pend;
                if (s < N_CH) m_pend = s;
                if (s == m_act) m_state = 0;
                else if (eof || m_tmo == TIMEOUT - 1) begin
                    m_act = old_pend; m_fc = 0;
                    m_state = (FLUSH_FRAMES == 0) ? 0 : 2;
                end else m_tmo++;
            end else begin
                if (eof) begin
                    m_fc++;
                    if (m_fc == FLUSH_FRAMES) begin
                        if (s < N_CH && s != m_act) begin
                            m_pend = s; m_tmo = 0; m_state = 1;
                        end else m_state = 0;
                    end
                end
            end
        end
        e_busy = (m_state != 0);
        e_act  = SEL_W'(m_act);
    end

    // ---------------- per-cycle comparison ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("o_we", 32'(o_we), 32'(e_o_we));
            if (e_o_we) begin
                chk("o_addr", 32'(o_addr), 32'(e_o_addr));
                chk("o_data", 32'(o_data), 32'(e_o_data));
            end
            chk("post_in_we", 32'(post_in_we), 32'(e_pi_we));
            chk("post_in_addr", 32'(post_in_addr), 32'(e_pi_addr));
            chk("post_in_data", 32'(post_in_data), 32'(e_pi_data));
            chk("frame_done", 32'(frame_done), 32'(e_fd));
            chk("busy", 32'(busy), 32'(e_busy));
            chk("active_sel", 32'(active_sel), 32'(e_act));
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- directed scenarios then random traffic ----------------
    initial begin
        int n, nwe, nbusy;
        reset = 1'b0; sel = '0; stall = '0; prob = 100;
        d0 = '0; d1 = '0; d2 = '0; a0 = '0; a1 = '0; a2 = '0;
        for (int k = 0; k < N_CH; k++) cnt[k] = 0;
        drive_inputs();
        post_out_we = 1'b0; post_out_addr = '0; post_out_data = '0;
        step();
        chk_en = 1'b1;
        step(); step();
        chk("rst_active", 32'(active_sel), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_o_we", 32'(o_we), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);

        // Full ramp on ch0: EOF pixel written and frame_done one cycle later.
        reset = 1'b1;
        for (int k = 0; k < N_CH; k++) cnt[k] = 0;
        drive_inputs();
        repeat (48) step();
        chk("ramp_frame_done", 32'(frame_done), 32'd1);
        chk("ramp_o_addr", 32'(o_addr), 32'd47);
        chk("ramp_o_we", 32'(o_we), 32'd1);
        step();
        chk("ramp_frame_done_low", 32'(frame_done), 32'd0);

        // Switch 0->3 mid-frame waits for ch0 EOF, then flushes one ch3 frame.
        sel = 3'd3;
        step();
        chk("sw_busy", 32'(busy), 32'd1);
        chk("sw_hold_active", 32'(active_sel), 32'd0);
        wait_until_active(3, 100, n);
        chk("sw_wait_cycles", 32'(n), 32'd46);
        chk("sw_eof_written_we", 32'(o_we), 32'd1);
        chk("sw_eof_written_addr", 32'(o_addr), 32'd47);
        nwe = 0; nbusy = 0;
        for (int i = 0; i < 48; i++) begin
            step();
            nwe += int'(o_we);
            if (i < 47) nbusy += int'(busy);
        end
        chk("flush_o_we_count", 32'(nwe), 32'd0);
        chk("flush_busy_count", 32'(nbusy), 32'd47);
        nwe = 0;
        for (int i = 0; i < 48; i++) begin
            step();
            nwe += int'(o_we);
        end
        chk("post_flush_writes", 32'(nwe), 32'd48);

        // Request withdrawn within the frame: back to RUN, no switch.
        sel = 3'd5;
        repeat (5) step();
        chk("cancel_busy_pend", 32'(busy), 32'd1);
        sel = 3'd3;
        step();
        chk("cancel_busy", 32'(busy), 32'd0);
        chk("cancel_active", 32'(active_sel), 32'd3);

        // Retarget while pending: the last request wins at the boundary.
        sel = 3'd1;
        repeat (3) step();
        sel = 3'd5;
        wait_until_active(5, 100, n);
        wait_until_idle(200);

        // Post-stage channel: frame buffer sees inverted data, addr with it.
        sel = 3'd4;
        wait_until_active(4, 200, n);
        wait_until_idle(200);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("post_inv_data", 32'(o_data), 32'(d2 ^ 16'hFFFF));
            chk("post_inv_addr", 32'(o_addr), 32'(a2));
        end
        sel = 3'd0;
        wait_until_active(0, 200, n);
        wait_until_idle(200);

        // Stalled active channel: forced switch after the timeout.
        stall[0] = 1'b1;
        sel = 3'd2;
        drive_inputs();
        step();
        chk("tmo_busy", 32'(busy), 32'd1);
        wait_until_active(2, 200, n);
        chk("tmo_cycles", 32'(n), 32'd64);
        cnt[2] = 0;
        repeat (3) step();
        chk("midflush_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        step();
        chk("midflush_rst_active", 32'(active_sel), 32'd0);
        chk("midflush_rst_o_we", 32'(o_we), 32'd0);
        chk("midflush_rst_busy", 32'(busy), 32'd0);
        reset = 1'b1;
        sel = 3'd0;
        stall = '0;

        // Randomized traffic including out-of-range requests and stalls.
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(0, 59) == 0) sel = SEL_W'($urandom_range(0, 7));
            if ($urandom_range(0, 199) == 0) prob = int'($urandom_range(40, 100));
            if ($urandom_range(0, 299) == 0) stall = N_CH'($urandom) & N_CH'($urandom);
            if ($urandom_range(0, 249) == 0) cnt[$urandom_range(0, N_CH-1)] = int'($urandom_range(0, FP-1));
            reset = ($urandom_range(0, 899) != 0);
            step();
        end
        reset = 1'b1;
        step();

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
